// File: rtl/rr_group_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_group_arbiter
// Description : N-way round-robin arbiter with registered, held grants and a
//               group-request / group-grant pair for cascading into trees.
//               Optional hold limit enabled by defining ARB_HOLD_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_group_arbiter #(
  parameter int N        = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N-1:0]    REQ,
  input  logic            GG,
  output logic            GR,
  output logic [N-1:0]    GNT,
  output logic            GNT_VLD,
  output logic [ID_W-1:0] GNT_ID
);

  localparam logic [0:0]      c_ST_IDLE = 1'b0;
  localparam logic [0:0]      c_ST_BUSY = 1'b1;
  localparam logic [ID_W-1:0] c_LAST    = ID_W'(N - 1);
  localparam logic [N-1:0]    c_ONE     = {{(N-1){1'b0}}, 1'b1};

  generate
    if ((N < 2) || (N > 16) || (N > (1 << ID_W)) || (HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_bad_param
      $error("rr_group_arbiter: illegal parameter combination");
    end
  endgenerate

  logic [0:0]      r_state;
  logic [ID_W-1:0] r_ptr;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_vld;
  logic [ID_W-1:0] r_gnt_id;

  logic [0:0]      w_state_nxt;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [N-1:0]    w_gnt_nxt;
  logic            w_gnt_vld_nxt;
  logic [ID_W-1:0] w_gnt_id_nxt;
  logic            w_new_grant;

  logic            w_any_req;
  logic            w_own_req;
  logic            w_hold_hit;
  logic            w_release;
  logic [ID_W-1:0] w_own_nxt;
  logic [ID_W-1:0] w_start;
  logic [N-1:0]    w_req_hi;
  logic [ID_W-1:0] w_win;

  function automatic logic [ID_W-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (v[j]) lowest_set = ID_W'(j);
    end
  endfunction

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] r_hold_cnt;

  // Counter restarts on every (re)grant, so the owner gets exactly HOLD_MAX cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hold_cnt <= '0;
    end else if (w_new_grant) begin
      r_hold_cnt <= '0;
    end else if (r_gnt_vld) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign w_hold_hit = r_gnt_vld && (r_hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign w_hold_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= c_ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_id  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
    end
  end

  // Searching from OWN+1 on release puts the current owner last in line.
  assign w_any_req = |REQ;
  assign w_own_req = |(REQ & r_gnt);
  assign w_own_nxt = (r_gnt_id == c_LAST) ? '0 : r_gnt_id + ID_W'(1);
  assign w_release = (r_state == c_ST_BUSY) && (!w_own_req || !GG || w_hold_hit);
  assign w_start   = (r_state == c_ST_BUSY) ? w_own_nxt : r_ptr;
  assign w_req_hi  = REQ & ({N{1'b1}} << w_start);
  assign w_win     = (|w_req_hi) ? lowest_set(w_req_hi) : lowest_set(REQ);

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_gnt_vld_nxt = r_gnt_vld;
    w_gnt_id_nxt  = r_gnt_id;
    w_new_grant   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (GG && w_any_req) begin
          w_state_nxt   = c_ST_BUSY;
          w_gnt_nxt     = c_ONE << w_win;
          w_gnt_vld_nxt = 1'b1;
          w_gnt_id_nxt  = w_win;
          w_new_grant   = 1'b1;
        end
      end
      c_ST_BUSY: begin
        if (w_release) begin
          w_ptr_nxt = w_own_nxt;
          if (GG && w_any_req) begin
            w_gnt_nxt     = c_ONE << w_win;
            w_gnt_vld_nxt = 1'b1;
            w_gnt_id_nxt  = w_win;
            w_new_grant   = 1'b1;
          end else begin
            w_state_nxt   = c_ST_IDLE;
            w_gnt_nxt     = '0;
            w_gnt_vld_nxt = 1'b0;
            w_gnt_id_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt   = c_ST_IDLE;
        w_gnt_nxt     = '0;
        w_gnt_vld_nxt = 1'b0;
        w_gnt_id_nxt  = '0;
      end
    endcase
  end

  // Outputs; GR bypasses state so a parent sees demand in the same cycle.
  always_comb begin
    GR      = w_any_req & ~RESET;
    GNT     = r_gnt;
    GNT_VLD = r_gnt_vld;
    GNT_ID  = r_gnt_id;
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_group_arbiter.sv
`default_nettype none
// Directed self-checking bench for rr_group_arbiter: an N=4 instance and an N=3 instance.
module tb_rr_group_arbiter;

  logic       CLK = 1'b0;
  logic       rst, gg, gr;
  logic [3:0] req, gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;

  logic       rst3, gg3, gr3;
  logic [2:0] req3, gnt3;
  logic       gnt_vld3;
  logic [1:0] gnt_id3;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rr_group_arbiter #(.N(4), .ID_W(2), .HOLD_MAX(3)) u_dut4 (
    .CLK(CLK), .RESET(rst), .REQ(req), .GG(gg), .GR(gr),
    .GNT(gnt), .GNT_VLD(gnt_vld), .GNT_ID(gnt_id)
  );

  rr_group_arbiter #(.N(3), .ID_W(2), .HOLD_MAX(3)) u_dut3 (
    .CLK(CLK), .RESET(rst3), .REQ(req3), .GG(gg3), .GR(gr3),
    .GNT(gnt3), .GNT_VLD(gnt_vld3), .GNT_ID(gnt_id3)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(e_gnt != 4'b0));
    chk({tag, ".id"},  32'(gnt_id), 32'(e_id));
  endtask

  task automatic chk3(input string tag, input logic [2:0] e_gnt, input logic [1:0] e_id);
    chk({tag, ".gnt"}, 32'(gnt3), 32'(e_gnt));
    chk({tag, ".vld"}, 32'(gnt_vld3), 32'(e_gnt != 3'b0));
    chk({tag, ".id"},  32'(gnt_id3), 32'(e_id));
  endtask

  initial begin
    rst = 1'b1; gg = 1'b1; req = 4'b1111;
    rst3 = 1'b1; gg3 = 1'b1; req3 = 3'b000;

    // Reset held for two edges with all requesters active
    step(); step();
    chk("rst.gr", 32'(gr), 32'd0);
    chk4("rst", 4'b0000, 2'd0);

    rst = 1'b0;
    #1;
    chk("rst_rel.gr", 32'(gr), 32'd1);
    step();
    chk4("first_grant", 4'b0001, 2'd0);

    // Fairness: each owner drops its request after two grant cycles
    for (int i = 0; i < 4; i++) begin
      step();
      chk4("fair.hold", 4'(1 << i), 2'(i));
      req = 4'b1111 & ~4'(1 << i);
      step();
      chk4("fair.next", 4'(1 << ((i + 1) % 4)), 2'((i + 1) % 4));
      req = 4'b1111;
    end

    // Back-to-back handoff, then drain to idle
    req = 4'b0101;
    step();
    chk4("b2b.hold", 4'b0001, 2'd0);
    req = 4'b0100;
    step();
    chk4("b2b.handoff", 4'b0100, 2'd2);
    req = 4'b0000;
    #1;
    chk("b2b.gr_low", 32'(gr), 32'd0);
    step();
    chk4("b2b.idle", 4'b0000, 2'd0);

    // Parent revoke: PTR=3 here, so the lone requester 1 wins
    req = 4'b0010;
    step();
    chk4("revoke.own1", 4'b0010, 2'd1);
    gg = 1'b0;
    step();
    chk4("revoke.drop", 4'b0000, 2'd0);
    chk("revoke.gr", 32'(gr), 32'd1);
    step();
    chk4("revoke.stay_idle", 4'b0000, 2'd0);
    gg = 1'b1;
    req = 4'b1010;
    step();
    chk4("revoke.ptr2", 4'b1000, 2'd3);

`ifdef ARB_HOLD_LIMIT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk4("hl.rst", 4'b0000, 2'd0);
    req = 4'b0011;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        chk4("hl.own0", 4'b0001, 2'd0);
      end
      for (int c = 0; c < 3; c++) begin
        step();
        chk4("hl.own1", 4'b0010, 2'd1);
      end
    end
    step();
    chk4("hl.back0", 4'b0001, 2'd0);
    req = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      step();
      chk4("hl.sole3", 4'b1000, 2'd3);
    end
`else
    // No hold limit: owner 3 keeps the grant well past HOLD_MAX cycles
    for (int c = 0; c < 12; c++) begin
      step();
      chk4("hold.indef", 4'b1000, 2'd3);
    end
`endif

    // N=3: mid-operation reset and pointer wrap
    rst3 = 1'b0;
    req3 = 3'b100;
    step();
    chk3("n3.own2", 3'b100, 2'd2);
    rst3 = 1'b1;
    #1;
    chk("n3.gr_rst", 32'(gr3), 32'd0);
    step();
    chk3("n3.rst", 3'b000, 2'd0);
    rst3 = 1'b0;
    req3 = 3'b101;
    step();
    chk3("n3.ptr0", 3'b001, 2'd0);
    req3 = 3'b100;
    step();
    chk3("n3.to2", 3'b100, 2'd2);
    req3 = 3'b001;
    step();
    chk3("n3.wrap", 3'b001, 2'd0);
    req3 = 3'b000;
    step();
    chk3("n3.idle", 3'b000, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
